// File: rtl/key_mode_sequencer_pkg.sv
// Shared definitions for the key-stepped mode sequencer.
// Holds the key FSM state encodings and the counter width helper.
package key_mode_sequencer_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE    = 2'd0,
    KEY_PRESSED = 2'd1,
    KEY_REPEAT  = 2'd2
  } key_state_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_mode_sequencer_key_press_gen.sv
// One push-button front end: 2-flop sync, debounce, press/hold/repeat FSM.
// step pulses one cycle on press and on each auto-repeat; held is the debounced pressed level.
module key_press_gen
  import key_mode_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic step,
  output logic held
);

  localparam int DB_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int RPT_W  = cnt_w(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  logic              sync1_q;
  logic              sync2_q;
  logic              deb_q;
  logic              deb_d;
  logic [DB_W-1:0]   db_cnt_q;
  logic [DB_W-1:0]   db_cnt_d;
  logic              deb_fall;
  logic              deb_rise;

  key_state_e        state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [RPT_W-1:0]  rpt_cnt_q;
  logic              step_q;

  // Counter runs only while the synchronised level disagrees with the debounced one.
  always_comb begin
    db_cnt_d = '0;
    deb_d    = deb_q;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Edges are taken from the next-state value so the step lands with the level change.
  assign deb_fall = deb_q & ~deb_d;
  assign deb_rise = ~deb_q & deb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      deb_q    <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= KEY_IDLE;
      hold_cnt_q <= '0;
      rpt_cnt_q  <= '0;
      step_q     <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        KEY_IDLE: begin
          if (deb_fall) begin
            step_q     <= 1'b1;
            state_q    <= KEY_PRESSED;
            hold_cnt_q <= '0;
          end
        end
        KEY_PRESSED: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (deb_rise) begin
            state_q <= KEY_IDLE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            step_q    <= 1'b1;
            state_q   <= KEY_REPEAT;
            rpt_cnt_q <= '0;
          end
        end
        KEY_REPEAT: begin
          // A release on the same cycle as a repeat tick wins; no step on release.
          if (deb_rise) begin
            state_q <= KEY_IDLE;
          end else if (rpt_cnt_q == RPT_LAST) begin
            step_q    <= 1'b1;
            rpt_cnt_q <= '0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= KEY_IDLE;
        end
      endcase
    end
  end

  assign step = step_q;
  assign held = ~deb_q;

endmodule

// File: rtl/key_mode_sequencer.sv
// Two-button mode stepper: UP/DOWN steps move a wrapping mode index one cycle later.
// mode_chg marks the cycle a new mode value appears; simultaneous UP and DOWN cancel.
module key_mode_sequencer
  import key_mode_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int NUM_MODES       = 4,
  parameter int MODE_W          = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_up_n,
  input  logic              key_dn_n,
  output logic [MODE_W-1:0] mode,
  output logic              mode_chg,
  output logic              busy
);

  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  logic              up_step;
  logic              dn_step;
  logic              up_held;
  logic              dn_held;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic              chg_q;
  logic              chg_d;

  key_press_gen #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_up_n),
    .step  (up_step),
    .held  (up_held)
  );

  key_press_gen #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_dn_n),
    .step  (dn_step),
    .held  (dn_held)
  );

  always_comb begin
    mode_d = mode_q;
    chg_d  = 1'b0;
    if (up_step && !dn_step) begin
      mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
      chg_d  = 1'b1;
    end else if (dn_step && !up_step) begin
      mode_d = (mode_q == '0) ? MODE_LAST : mode_q - 1'b1;
      chg_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      chg_q  <= chg_d;
    end
  end

  assign mode     = mode_q;
  assign mode_chg = chg_q;
  assign busy     = up_held | dn_held;

endmodule

// File: tb/tb_key_mode_sequencer.sv
// Bench for key_mode_sequencer with short debounce/hold/repeat times.
module tb_key_mode_sequencer;

  localparam int D  = 4;
  localparam int H  = 16;
  localparam int R  = 8;
  localparam int NM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic [1:0] mode;
  logic       mode_chg;
  logic       busy;

  int checks = 0;
  int failures = 0;

  key_mode_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R),
    .NUM_MODES       (NM),
    .MODE_W          (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_up_n (key_up_n),
    .key_dn_n (key_dn_n),
    .mode     (mode),
    .mode_chg (mode_chg),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a key's debounced level flips once D consecutive synchronised
  // samples (raw delayed two clocks) disagree with it; press/hold/repeat steps are
  // derived from the clock count since the debounced press.
  int m_mode;
  int m_chg;
  int m_n;
  bit m_deb [2];
  bit m_stp [2];
  int m_p   [2];
  bit hist  [2][D+2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_chg  = 0;
      m_n    = 0;
      for (int k = 0; k < 2; k++) begin
        m_deb[k] = 1'b1;
        m_stp[k] = 1'b0;
        m_p[k]   = 0;
        for (int j = 0; j <= D + 1; j++) hist[k][j] = 1'b1;
      end
    end else begin
      m_n++;
      m_chg = (m_stp[0] != m_stp[1]) ? 1 : 0;
      if (m_stp[0] && !m_stp[1]) m_mode = (m_mode + 1) % NM;
      else if (m_stp[1] && !m_stp[0]) m_mode = (m_mode + NM - 1) % NM;
      for (int k = 0; k < 2; k++) begin
        int agree;
        int len;
        for (int j = D + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = (k == 0) ? key_up_n : key_dn_n;
        agree = 0;
        for (int j = 2; j <= D + 1; j++) if (hist[k][j] == m_deb[k]) agree++;
        m_stp[k] = 1'b0;
        if (agree == 0) begin
          m_deb[k] = !m_deb[k];
          if (!m_deb[k]) begin
            m_p[k]   = m_n;
            m_stp[k] = 1'b1;
          end
        end else if (!m_deb[k]) begin
          len = m_n - m_p[k];
          if (len == H || (len > H && (len - H) % R == 0)) m_stp[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_mode", int'(mode), m_mode);
    chk("model_chg", int'(mode_chg), m_chg);
    chk("model_busy", int'(busy), (!m_deb[0] || !m_deb[1]) ? 1 : 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mode", int'(mode), 0);
    chk("rst_chg", int'(mode_chg), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input bit dn, input int low, input int high);
    if (dn) key_dn_n = 1'b0; else key_up_n = 1'b0;
    tick(low);
    if (dn) key_dn_n = 1'b1; else key_up_n = 1'b1;
    tick(high);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(2);

    // 1: single press, latency of 7 clocks from the raw edge
    do_reset();
    key_up_n = 1'b0;
    tick(6);
    chk("t1_mode_before", int'(mode), 0);
    chk("t1_busy", int'(busy), 1);
    tick(1);
    chk("t1_mode_after", int'(mode), 1);
    chk("t1_chg_pulse", int'(mode_chg), 1);
    tick(1);
    chk("t1_chg_single", int'(mode_chg), 0);
    tick(2);
    key_up_n = 1'b1;
    tick(20);
    chk("t1_mode_final", int'(mode), 1);
    chk("t1_busy_rel", int'(busy), 0);

    // 2: glitch shorter than the debounce window
    do_reset();
    key_up_n = 1'b0;
    tick(3);
    key_up_n = 1'b1;
    tick(15);
    chk("t2_mode", int'(mode), 0);

    // 3: wrap forward and backward
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      press(1'b0, 8, 10);
      chk("t3_up_mode", int'(mode), i % NM);
    end
    do_reset();
    press(1'b1, 8, 10);
    chk("t3_dn_wrap", int'(mode), 3);

    // 4: hold with auto-repeat, release coincident with a repeat tick
    do_reset();
    key_up_n = 1'b0;
    tick(7);
    chk("t4_press", int'(mode), 1);
    tick(15);
    chk("t4_pre_hold", int'(mode), 1);
    tick(1);
    chk("t4_hold", int'(mode), 2);
    tick(8);
    chk("t4_rpt1", int'(mode), 3);
    tick(8);
    chk("t4_rpt2", int'(mode), 0);
    tick(1);
    key_up_n = 1'b1;
    tick(17);
    chk("t4_release", int'(mode), 0);
    chk("t4_busy", int'(busy), 0);

    // 5: simultaneous UP and DOWN cancel
    do_reset();
    key_up_n = 1'b0;
    key_dn_n = 1'b0;
    tick(6);
    chk("t5_busy", int'(busy), 1);
    tick(1);
    chk("t5_mode", int'(mode), 0);
    chk("t5_chg", int'(mode_chg), 0);
    tick(10);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    tick(10);
    chk("t5_mode_end", int'(mode), 0);

    // 6: reset while repeating, key still held afterwards
    do_reset();
    key_up_n = 1'b0;
    tick(30);
    chk("t6_pre", int'(mode), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_mode", int'(mode), 0);
    chk("t6_rst_busy", int'(busy), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    tick(6);
    chk("t6_mode_wait", int'(mode), 0);
    tick(1);
    chk("t6_mode_fresh", int'(mode), 1);
    key_up_n = 1'b1;
    tick(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
